// File: rtl/wb_master_if.sv
// Single-request Wishbone B4 classic master: CPU load/store -> bus cycle with lane steering,
// misalignment/ERR/timeout reporting. Define WB_RETRY_EN to add RTY_I handling (GAP state).
module wb_master_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              I_en,
  input  logic [2:0]        I_op,
  input  logic [ADDR_W-1:0] I_addr,
  input  logic [31:0]       I_data,
  output logic [31:0]       O_data,
  output logic              O_busy,
  output logic              O_done,
  output logic [1:0]        O_err,
  input  logic              ACK_I,
  input  logic              ERR_I,
  input  logic [DATA_W-1:0] DAT_I,
  output logic [ADDR_W-1:0] ADR_O,
  output logic [DATA_W-1:0] DAT_O,
  output logic [DATA_W/8-1:0] SEL_O,
  output logic              CYC_O,
  output logic              STB_O,
`ifdef WB_RETRY_EN
  input  logic              RTY_I,
`endif
  output logic              WE_O
);

  localparam int LANES = DATA_W / 8;
  localparam int OFS   = $clog2(LANES);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
`ifdef WB_RETRY_EN
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
`endif

  localparam logic [2:0] BUSOP_READB  = 3'd0;
  localparam logic [2:0] BUSOP_READBU = 3'd1;
  localparam logic [2:0] BUSOP_READH  = 3'd2;
  localparam logic [2:0] BUSOP_READHU = 3'd3;
  localparam logic [2:0] BUSOP_READW  = 3'd4;
  localparam logic [2:0] BUSOP_WRITEB = 3'd5;
  localparam logic [2:0] BUSOP_WRITEH = 3'd6;
  localparam logic [2:0] BUSOP_WRITEW = 3'd7;

  typedef enum logic [1:0] {IDLE, BUS, GAP} state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [OFS-1:0]      off_q, off_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic [LANES-1:0]    sel_q, sel_d;
  logic                we_q, we_d;
  logic                cyc_q, cyc_d;
  logic                done_q, done_d;
  logic [1:0]          err_q, err_d;
  logic [31:0]         data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`ifdef WB_RETRY_EN
  logic [RTY_W-1:0]    rty_q, rty_d;
`endif

  // Request decode on the raw inputs (only meaningful in IDLE)
  logic                in_half, in_word, in_write, misaligned;
  logic [OFS-1:0]      in_off;
  logic [LANES-1:0]    base_sel;
  logic [DATA_W-1:0]   st_data;

  always_comb begin
    in_half    = (I_op == BUSOP_READH) || (I_op == BUSOP_READHU) || (I_op == BUSOP_WRITEH);
    in_word    = (I_op == BUSOP_READW) || (I_op == BUSOP_WRITEW);
    in_write   = (I_op == BUSOP_WRITEB) || (I_op == BUSOP_WRITEH) || (I_op == BUSOP_WRITEW);
    misaligned = (in_half && I_addr[0]) || (in_word && (I_addr[1:0] != 2'b00));
    in_off     = I_addr[OFS-1:0];
    base_sel   = LANES'(4'b0001);
    st_data    = DATA_W'(I_data[7:0]);
    if (in_word) begin
      base_sel = LANES'(4'b1111);
      st_data  = DATA_W'(I_data);
    end else if (in_half) begin
      base_sel = LANES'(4'b0011);
      st_data  = DATA_W'(I_data[15:0]);
    end
  end

  // Load path: shift the addressed lanes down, then trim and extend by op
  logic [DATA_W-1:0] rd_sh;
  logic [31:0]       rd_val;
  logic              rd_op;

  always_comb begin
    rd_sh  = DAT_I >> {off_q, 3'b000};
    rd_op  = (op_q <= BUSOP_READW);
    rd_val = rd_sh[31:0];
    case (op_q)
      BUSOP_READB:  rd_val = {{24{rd_sh[7]}}, rd_sh[7:0]};
      BUSOP_READBU: rd_val = {24'd0, rd_sh[7:0]};
      BUSOP_READH:  rd_val = {{16{rd_sh[15]}}, rd_sh[15:0]};
      BUSOP_READHU: rd_val = {16'd0, rd_sh[15:0]};
      default:      rd_val = rd_sh[31:0];
    endcase
  end

  logic       fin;
  logic [1:0] fin_err;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    off_d   = off_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    done_d  = 1'b0;
    err_d   = err_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
`ifdef WB_RETRY_EN
    rty_d   = rty_q;
`endif
    fin     = 1'b0;
    fin_err = 2'b00;

    case (state_q)
      IDLE: begin
        if (I_en) begin
          if (misaligned) begin
            done_d = 1'b1;
            err_d  = 2'b01;
          end else begin
            state_d = BUS;
            op_d    = I_op;
            off_d   = in_off;
            adr_d   = {I_addr[ADDR_W-1:OFS], {OFS{1'b0}}};
            sel_d   = base_sel << in_off;
            dat_d   = in_write ? (st_data << {in_off, 3'b000}) : '0;
            we_d    = in_write;
            cyc_d   = 1'b1;
            cnt_d   = '0;
`ifdef WB_RETRY_EN
            rty_d   = '0;
`endif
          end
        end
      end
      BUS: begin
        if (ERR_I) begin
          fin     = 1'b1;
          fin_err = 2'b10;
          if (rd_op) data_d = 32'd0;
        end else if (ACK_I) begin
          fin     = 1'b1;
          fin_err = 2'b00;
          if (rd_op) data_d = rd_val;
`ifdef WB_RETRY_EN
        end else if (RTY_I) begin
          if (rty_q == RTY_W'(MAX_RETRY)) begin
            fin     = 1'b1;
            fin_err = 2'b11;
          end else begin
            rty_d   = rty_q + 1'b1;
            cyc_d   = 1'b0;
            state_d = GAP;
          end
`endif
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          fin     = 1'b1;
          fin_err = 2'b11;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        // Re-issue the held request with a fresh timeout window
        state_d = BUS;
        cyc_d   = 1'b1;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase

    if (fin) begin
      state_d = IDLE;
      cyc_d   = 1'b0;
      we_d    = 1'b0;
      sel_d   = '0;
      dat_d   = '0;
      adr_d   = '0;
      done_d  = 1'b1;
      err_d   = fin_err;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      op_q    <= '0;
      off_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 2'b00;
      data_q  <= '0;
      cnt_q   <= '0;
`ifdef WB_RETRY_EN
      rty_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      off_q   <= off_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
      err_q   <= err_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
`ifdef WB_RETRY_EN
      rty_q   <= rty_d;
`endif
    end
  end

  assign O_data = data_q;
  assign O_busy = (state_q != IDLE);
  assign O_done = done_q;
  assign O_err  = err_q;
  assign ADR_O  = adr_q;
  assign DAT_O  = dat_q;
  assign SEL_O  = sel_q;
  assign CYC_O  = cyc_q;
  assign STB_O  = cyc_q;
  assign WE_O   = we_q;

endmodule

// File: doc/wb_master_if.md
Name: wb_master_if

Overview:
- Parametrised successor to the CPU-side Wishbone B4 master. Converts single CPU load/store requests into classic Wishbone cycles.
- Generalises over the current master:
  - configurable data/address width
  - byte-lane steering from low address bits
  - misalignment detection
  - ERR_I handling
  - bus timeout
  - explicit done/error reporting
- Sits between the CPU load/store unit and the system bus interconnect (RAM, devices).

Parameters:
- DATA_W, 32, bus data width; 32 or 64 only. LANES=DATA_W/8, OFS=log2(LANES).
- ADDR_W, 32, address width.
- TIMEOUT, 255, max cycles waiting for ACK_I/ERR_I per attempt; 0 disables the timeout.
- MAX_RETRY, 3, retry attempts; used only with WB_RETRY_EN.

Ports:
- CLK_I  in  1  clock.
- RST_I  in  1  async active-high reset.
- I_en  in  1  request strobe; sampled only while idle.
- I_op  in  3  operation; BUSOP_* encodings from busdefs.vh (READB/READBU/READH/READHU/READW/WRITEB/WRITEH/WRITEW).
- I_addr  in  ADDR_W  byte address.
- I_data  in  32  store data, right-aligned.
- O_data  out  32  load result, extended.
- O_busy  out  1  request in progress.
- O_done  out  1  one-cycle completion pulse.
- O_err  out  2  status with O_done: 00 ok, 01 misaligned, 10 bus error, 11 timeout/retry exhausted.
- ACK_I  in  1  Wishbone ack.
- ERR_I  in  1  Wishbone error.
- DAT_I  in  DATA_W  read data.
- ADR_O  out  ADDR_W  lane-aligned address.
- DAT_O  out  DATA_W  write data.
- SEL_O  out  LANES  byte selects.
- CYC_O  out  1  cycle.
- STB_O  out  1  strobe.
- WE_O  out  1  write enable.
- RTY_I  in  1  Wishbone retry; exists only with WB_RETRY_EN.

Behaviour:
- Reset: async. While RST_I is high and after release:
  - all outputs are 0
  - FSM is IDLE; counters are 0
  - reset mid-cycle drops CYC_O/STB_O immediately and the request is lost.
- FSM states: IDLE, BUS, GAP (GAP is used only with WB_RETRY_EN).
- Accept, IDLE only: I_en=1 at edge T captures op/addr/data. While O_busy=1, I_en is ignored.
- Misalignment check at accept:
  - a half access with addr[0]=1 is misaligned
  - a word access with addr[1:0]!=0 is misaligned.
  - On misalignment: no bus cycle; after edge T, O_done=1, O_err=01, O_busy=0, O_data unchanged.
- Aligned request: after edge T, state is BUS and the following hold:
  - O_busy=1, CYC_O=STB_O=1, WE_O=write.
  - ADR_O = addr with low OFS bits zeroed.
  - SEL_O = base mask (byte 1, half 11, word 1111) << addr[OFS-1:0].
  - DAT_O = store data shifted left by 8*addr[OFS-1:0]; unselected lanes are 0.
  - These outputs are held stable until termination.
- Termination, sampled at an edge while in BUS:
  - ERR_I=1 → O_err=10; a read sets O_data=0. ERR_I wins over simultaneous ACK_I.
  - ACK_I=1 → O_err=00. A read captures DAT_I >> 8*offset, then:
    - byte: bits[7:0]; half: bits[15:0]
    - READB/READH sign-extend; READBU/READHU zero-extend; READW takes 32 bits.
  - Writes leave O_data unchanged.
  - After the terminating edge: CYC_O=STB_O=WE_O=0, SEL_O=0, O_done=1 for one cycle, O_busy=0, state IDLE.
- Timeout:
  - A cycle counter runs in BUS and clears on entry.
  - If TIMEOUT!=0 and the count reaches TIMEOUT with no ACK_I/ERR_I, the cycle ends as above with O_err=11.
- Latency with zero-wait-state ACK:
  - I_en edge 0, CYC_O high after edge 0, ACK sampled at edge 1, O_done high after edge 1.
  - O_data is valid in the O_done cycle and held until the next completed read.
- Back-to-back: I_en asserted during the O_done cycle is accepted; no idle bubble is required beyond that cycle.
- ACK_I/ERR_I seen outside BUS are ignored.

Optional Feature:
- Macro: WB_RETRY_EN.
- With the macro:
  - RTY_I exists.
  - RTY_I=1 in BUS with ACK_I=ERR_I=0 → drop CYC_O/STB_O for one cycle (GAP), then re-issue identical ADR/SEL/DAT/WE. The timeout counter restarts.
  - After MAX_RETRY retries, a further RTY_I completes with O_err=11.
  - Priority: ERR_I > ACK_I > RTY_I.
- Without the macro: no RTY_I port, no GAP state, and MAX_RETRY is unused.

Test Plan:
- READW addr 0x100, ACK next cycle, DAT_I=0xDEADBEEF → ADR_O=0x100, SEL_O=1111, O_data=0xDEADBEEF, O_err=00, O_done one cycle after ACK.
- READB addr 0x103, DAT_I=0x80FF_1234 → SEL_O=1000, O_data=0xFFFFFF80. READBU → 0x00000080.
- WRITEH addr 0x202, I_data=0x0000ABCD → SEL_O=1100, DAT_O[31:16]=0xABCD, WE_O=1 until ACK, then all bus outputs 0.
- READH addr 0x101 → no CYC_O; O_done with O_err=01. Separately, READW with ERR_I and ACK_I asserted together → O_err=10, O_data=0.
- TIMEOUT=4, never ACK → CYC_O drops after 4 BUS cycles, O_err=11. Separately, assert RST_I mid-cycle → CYC_O=0 immediately.
- WB_RETRY_EN, MAX_RETRY=3: RTY twice then ACK → two one-cycle CYC_O gaps, O_err=00. Four RTYs → O_err=11.
